multicycle_control_fsm: RTL and testbench

Control unit for the multicycle implementation of the processor's ARM subset. It is the parametrised successor of the single-cycle main decoder and covers the same instruction classes: data processing (register and immediate), LDR, STR and B. It sequences each instruction through fetch, decode, execute, memory and writeback states. It adds configurable memory wait states, condition-failed squashing and illegal-opcode reporting. It sits between the instruction register / condition logic and the datapath multiplexers.

---
 rtl/multicycle_control_fsm.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit for the ARM subset: sequences fetch, decode, execute,
// memory and writeback states, with configurable fetch and memory wait states.
module multicycle_control_fsm #(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       CondEx,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemW,
    output logic       IRWrite,
    output logic       RegW,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp,
    output logic       Branch,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       Done,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExecR  = 4'd7,
        StExecI  = 4'd8,
        StAluWb  = 4'd9,
        StBranch = 4'd10
    } state_t;

    localparam logic [3:0] FetchLim = 4'(FETCH_WAIT);
    localparam logic [3:0] MemLim   = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lim;
    logic       waiting;
    logic       last;

    // Funct[4:1] only matter to the ALU decoder, not to sequencing.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        waiting = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
        lim     = (state_q == StFetch) ? FetchLim : MemLim;
        last    = (cnt_q == lim);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (last) state_d = StDecode;
            StDecode: begin
                if (Op == 2'b11)            state_d = StFetch;
                else if (!CondEx)           state_d = StFetch;
                else if (Op == 2'b00)       state_d = Funct[5] ? StExecI : StExecR;
                else if (Op == 2'b01)       state_d = StMemAdr;
                else                        state_d = StBranch;
            end
            StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd:  if (last) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (last) state_d = StFetch;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    // The counter restarts on every state change so each wait state counts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = 4'd0;
        end else if (waiting && !last) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        RegW      = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 1'b0;
        Branch    = 1'b0;
        Done      = 1'b0;
        Illegal   = 1'b0;
        unique case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = last;
                PCWrite   = last;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (Op == 2'b11) begin
                    Illegal = 1'b1;
                    Done    = 1'b1;
                end else if (!CondEx) begin
                    Done = 1'b1;
                end
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
                Done      = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                Done   = last;
            end
            StExecR: ALUOp = 1'b1;
            StExecI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            StAluWb: begin
                RegW = 1'b1;
                Done = 1'b1;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
                PCWrite   = 1'b1;
                Done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign ImmSrc    = Op;
    assign RegSrc[1] = (Op == 2'b01) && !Funct[0];
    assign RegSrc[0] = (Op == 2'b10);
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: three differently parametrised
// instances are exercised one at a time through a shared monitor.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn [3];
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       CondEx;

    logic       pcw_w [3], adr_w [3], memw_w [3], irw_w [3], regw_w [3];
    logic       alua_w [3], aluop_w [3], br_w [3], done_w [3], ill_w [3];
    logic [1:0] rs_w [3], alub_w [3], imm_w [3], rsrc_w [3];
    logic [3:0] st_w [3];

    int sel = 0;

    multicycle_control_fsm #(.FETCH_WAIT(0), .MEM_WAIT(2)) u0 (
        .clk(clk), .rst_n(rstn[0]), .Op(Op), .Funct(Funct), .CondEx(CondEx),
        .PCWrite(pcw_w[0]), .AdrSrc(adr_w[0]), .MemW(memw_w[0]), .IRWrite(irw_w[0]),
        .RegW(regw_w[0]), .ResultSrc(rs_w[0]), .ALUSrcA(alua_w[0]), .ALUSrcB(alub_w[0]),
        .ALUOp(aluop_w[0]), .Branch(br_w[0]), .ImmSrc(imm_w[0]), .RegSrc(rsrc_w[0]),
        .Done(done_w[0]), .Illegal(ill_w[0]), .State(st_w[0])
    );

    multicycle_control_fsm #(.FETCH_WAIT(3), .MEM_WAIT(1)) u1 (
        .clk(clk), .rst_n(rstn[1]), .Op(Op), .Funct(Funct), .CondEx(CondEx),
        .PCWrite(pcw_w[1]), .AdrSrc(adr_w[1]), .MemW(memw_w[1]), .IRWrite(irw_w[1]),
        .RegW(regw_w[1]), .ResultSrc(rs_w[1]), .ALUSrcA(alua_w[1]), .ALUSrcB(alub_w[1]),
        .ALUOp(aluop_w[1]), .Branch(br_w[1]), .ImmSrc(imm_w[1]), .RegSrc(rsrc_w[1]),
        .Done(done_w[1]), .Illegal(ill_w[1]), .State(st_w[1])
    );

    multicycle_control_fsm #(.FETCH_WAIT(0), .MEM_WAIT(3)) u2 (
        .clk(clk), .rst_n(rstn[2]), .Op(Op), .Funct(Funct), .CondEx(CondEx),
        .PCWrite(pcw_w[2]), .AdrSrc(adr_w[2]), .MemW(memw_w[2]), .IRWrite(irw_w[2]),
        .RegW(regw_w[2]), .ResultSrc(rs_w[2]), .ALUSrcA(alua_w[2]), .ALUSrcB(alub_w[2]),
        .ALUOp(aluop_w[2]), .Branch(br_w[2]), .ImmSrc(imm_w[2]), .RegSrc(rsrc_w[2]),
        .Done(done_w[2]), .Illegal(ill_w[2]), .State(st_w[2])
    );

    logic       m_rst, m_pcw, m_adr, m_memw, m_irw, m_regw, m_alua, m_aluop, m_br;
    logic       m_done, m_ill;
    logic [1:0] m_rs, m_alub, m_imm, m_rsrc;
    logic [3:0] m_st;

    always_comb begin
        m_rst  = rstn[sel];
        m_pcw  = pcw_w[sel];
        m_adr  = adr_w[sel];
        m_memw = memw_w[sel];
        m_irw  = irw_w[sel];
        m_regw = regw_w[sel];
        m_alua = alua_w[sel];
        m_aluop = aluop_w[sel];
        m_br   = br_w[sel];
        m_done = done_w[sel];
        m_ill  = ill_w[sel];
        m_rs   = rs_w[sel];
        m_alub = alub_w[sel];
        m_imm  = imm_w[sel];
        m_rsrc = rsrc_w[sel];
        m_st   = st_w[sel];
    end

    // Per-instruction record; masks carry one bit per cycle, cycle 0 = first FETCH cycle.
    typedef struct packed {
        logic [63:0] name;
        logic [63:0] seq;
        logic [7:0]  cycles;
        logic [15:0] regw;
        logic [15:0] memw;
        logic [15:0] pcw;
        logic [15:0] irw;
        logic [15:0] adr;
        logic [15:0] br;
        logic [15:0] ill;
        logic [1:0]  rs;
        logic [1:0]  imm;
        logic [1:0]  rsrc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input exp_t o);
        check($sformatf("%0s.states", e.name), o.seq, e.seq);
        check($sformatf("%0s.cycles", e.name), 64'(o.cycles), 64'(e.cycles));
        check($sformatf("%0s.regw", e.name), 64'(o.regw), 64'(e.regw));
        check($sformatf("%0s.memw", e.name), 64'(o.memw), 64'(e.memw));
        check($sformatf("%0s.pcwrite", e.name), 64'(o.pcw), 64'(e.pcw));
        check($sformatf("%0s.irwrite", e.name), 64'(o.irw), 64'(e.irw));
        check($sformatf("%0s.adrsrc", e.name), 64'(o.adr), 64'(e.adr));
        check($sformatf("%0s.branch", e.name), 64'(o.br), 64'(e.br));
        check($sformatf("%0s.illegal", e.name), 64'(o.ill), 64'(e.ill));
        check($sformatf("%0s.resultsrc_wb", e.name), 64'(o.rs), 64'(e.rs));
        check($sformatf("%0s.immsrc", e.name), 64'(o.imm), 64'(e.imm));
        check($sformatf("%0s.regsrc", e.name), 64'(o.rsrc), 64'(e.rsrc));
    endtask

    initial begin : monitor
        exp_t obs;
        bit   in_prog;
        bit   prev_pcw;
        int   idx;
        in_prog  = 1'b0;
        prev_pcw = 1'b0;
        idx      = 0;
        obs      = '0;
        forever begin
            @(negedge clk);
            if (!m_rst) begin
                in_prog  = 1'b0;
                prev_pcw = 1'b0;
            end else begin
                if (m_st == 4'd0) check("done_in_idle", 64'(m_done), 64'd0);
                if (m_pcw) check("pcwrite_back_to_back", 64'(prev_pcw), 64'd0);
                prev_pcw = m_pcw;
                if (m_st == 4'd1 && !in_prog) begin
                    in_prog = 1'b1;
                    idx     = 0;
                    obs     = '0;
                    obs.rs  = 2'b11;
                end
                if (in_prog) begin
                    obs.seq = {obs.seq[59:0], m_st};
                    if (idx < 16) begin
                        obs.regw[idx[3:0]] = m_regw;
                        obs.memw[idx[3:0]] = m_memw;
                        obs.pcw[idx[3:0]]  = m_pcw;
                        obs.irw[idx[3:0]]  = m_irw;
                        obs.adr[idx[3:0]]  = m_adr;
                        obs.br[idx[3:0]]   = m_br;
                        obs.ill[idx[3:0]]  = m_ill;
                    end
                    if (m_regw) obs.rs = m_rs;
                    idx++;
                    if (m_done) begin
                        obs.cycles = 8'(idx);
                        obs.imm    = m_imm;
                        obs.rsrc   = m_rsrc;
                        in_prog    = 1'b0;
                        done_cnt++;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got Done in state %0d, required none", m_st);
                        end else begin
                            compare(exp_q.pop_front(), obs);
                        end
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input logic [63:0] name, input logic [63:0] seq,
                                input int cycles, input logic [15:0] regw,
                                input logic [15:0] memw, input logic [15:0] pcw,
                                input logic [15:0] irw, input logic [15:0] adr,
                                input logic [15:0] br, input logic [15:0] ill,
                                input logic [1:0] rs, input logic [1:0] imm,
                                input logic [1:0] rsrc);
        exp_t e;
        e.name = name; e.seq = seq; e.cycles = 8'(cycles);
        e.regw = regw; e.memw = memw; e.pcw = pcw; e.irw = irw; e.adr = adr;
        e.br = br; e.ill = ill; e.rs = rs; e.imm = imm; e.rsrc = rsrc;
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] funct, input logic cond,
                         input exp_t e, output int want);
        Op     = op;
        Funct  = funct;
        CondEx = cond;
        exp_q.push_back(e);
        want = done_cnt + exp_q.size();
    endtask

    task automatic wait_done(input int want);
        int n = 0;
        while (done_cnt < want && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt < want) begin
            checks++;
            errors++;
            $display("FAIL timeout: done count %0d, required %0d", done_cnt, want);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] funct, input logic cond,
                       input exp_t e);
        int want;
        issue(op, funct, cond, e, want);
        wait_done(want);
    endtask

    function automatic logic [13:0] outs();
        return {m_pcw, m_adr, m_memw, m_irw, m_regw, m_rs, m_alua, m_alub, m_aluop,
                m_br, m_done, m_ill};
    endfunction

    task automatic release_dut(input int k);
        @(posedge clk);
        #1;
        rstn[k] = 1'b1;
        @(negedge clk);
        check("state_after_release", 64'(m_st), 64'd0);
        check("outputs_after_release", 64'(outs()), 64'd0);
        @(posedge clk);
        #1;
        check("state_fetch_after_idle", 64'(m_st), 64'd1);
    endtask

    initial begin : stimulus
        int want;
        int n;
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        rstn[2] = 1'b0;
        Op      = 2'b00;
        Funct   = 6'b0;
        CondEx  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // F=0, M=2: DP, LDR, squash, illegal
        sel = 0;
        #1;
        check("reset_state", 64'(m_st), 64'd0);
        check("reset_outputs", 64'(outs()), 64'd0);
        issue(2'b00, 6'b001000, 1'b1,
              mk("dp_reg", 64'h1279, 4, 16'h8, 16'h0, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0,
                 2'b00, 2'b00, 2'b00), want);
        release_dut(0);
        wait_done(want);
        run(2'b00, 6'b100000, 1'b1,
            mk("dp_imm", 64'h1289, 4, 16'h8, 16'h0, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0,
               2'b00, 2'b00, 2'b00));
        run(2'b01, 6'b011001, 1'b1,
            mk("ldr", 64'h1234445, 7, 16'h40, 16'h0, 16'h1, 16'h1, 16'h38, 16'h0, 16'h0,
               2'b01, 2'b01, 2'b00));
        run(2'b00, 6'b001000, 1'b0,
            mk("squash", 64'h12, 2, 16'h0, 16'h0, 16'h1, 16'h1, 16'h0, 16'h0, 16'h0,
               2'b11, 2'b00, 2'b00));
        run(2'b11, 6'b000000, 1'b0,
            mk("illegal", 64'h12, 2, 16'h0, 16'h0, 16'h1, 16'h1, 16'h0, 16'h0, 16'h2,
               2'b11, 2'b11, 2'b00));
        rstn[0] = 1'b0;

        // F=3, M=1: branch and store
        sel = 1;
        #1;
        check("reset_state_u1", 64'(m_st), 64'd0);
        issue(2'b10, 6'b000000, 1'b1,
              mk("branch", 64'h11112A, 6, 16'h0, 16'h0, 16'h28, 16'h08, 16'h0, 16'h20,
                 16'h0, 2'b11, 2'b10, 2'b01), want);
        release_dut(1);
        wait_done(want);
        run(2'b01, 6'b000000, 1'b1,
            mk("str", 64'h11112366, 8, 16'h0, 16'hC0, 16'h08, 16'h08, 16'hC0, 16'h0, 16'h0,
               2'b11, 2'b01, 2'b10));
        rstn[1] = 1'b0;

        // F=0, M=3: reset dropped on the second MEMWR cycle
        sel = 2;
        Op = 2'b01;
        Funct = 6'b000000;
        CondEx = 1'b1;
        release_dut(2);
        n = 0;
        while (m_st != 4'd6 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_memwr", 64'(m_st), 64'd6);
        @(posedge clk);
        #1;
        check("memwr_second_state", 64'(m_st), 64'd6);
        check("memwr_second_memw", 64'(m_memw), 64'd1);
        rstn[2] = 1'b0;
        #1;
        check("rst_memw_drop", 64'(m_memw), 64'd0);
        check("rst_state_zero", 64'(m_st), 64'd0);
        check("rst_outputs_zero", 64'(outs()), 64'd0);
        issue(2'b01, 6'b000000, 1'b1,
              mk("str_rst", 64'h1236666, 7, 16'h0, 16'h78, 16'h1, 16'h1, 16'h78, 16'h0,
                 16'h0, 2'b11, 2'b01, 2'b10), want);
        release_dut(2);
        wait_done(want);
        rstn[2] = 1'b0;

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
